scanline_irq_scheduler: RTL and testbench

SCANLINE_IRQ_SCHEDULER -- requirements
Module: scanline_irq_scheduler

---
 rtl/scanline_irq_scheduler_pkg.sv | 18 +
 rtl/scanline_irq_scheduler_if.sv | 20 ++
 rtl/a12_edge_filter.sv | 49 ++++
 rtl/scanline_irq_scheduler.sv | 95 +++++++++
 tb/tb_scanline_irq_scheduler.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/scanline_irq_scheduler_pkg.sv
// Shared configuration for the scanline IRQ scheduler: build-time enable and
// the {A13,A0} register-select encodings of the $C000-$FFFF register window.
package scanline_irq_scheduler_pkg;

  localparam bit ENABLE_SCANLINE_IRQ = 1'b1;

  typedef enum logic [1:0] {
    RegC000 = 2'b00,
    RegC001 = 2'b01,
    RegE000 = 2'b10,
    RegE001 = 2'b11
  } reg_sel_e;

  function automatic reg_sel_e reg_sel_of(input logic [14:0] addr);
    return reg_sel_e'({addr[13], addr[0]});
  endfunction

endpackage

// File: rtl/scanline_irq_scheduler_if.sv
// CPU bus, PPU A12 and IRQ signals between the cartridge logic and the scheduler.
interface scanline_irq_scheduler_if;
  logic        romsel;
  logic        cpu_rw_in;
  logic [14:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;
  logic        ppu_a12;
  logic        irq;
  logic        irq_pending;

  modport master (
    output romsel, cpu_rw_in, cpu_addr_in, cpu_data_in, ppu_a12,
    input  irq, irq_pending
  );

  modport slave (
    input  romsel, cpu_rw_in, cpu_addr_in, cpu_data_in, ppu_a12,
    output irq, irq_pending
  );
endinterface

// File: rtl/a12_edge_filter.sv
// Synchronises PPU A12 into the m2 domain and emits a one-cycle a12_clock pulse
// on a rising edge that follows at least A12_LOW_MIN synchronised low cycles.
module a12_edge_filter #(
  parameter int unsigned A12_LOW_MIN = 3,
  parameter bit          ENABLE      = 1'b1
) (
  input  logic m2,
  input  logic not_reset,
  input  logic ppu_a12,
  output logic a12_clock
);

  localparam int unsigned LW = $clog2(A12_LOW_MIN + 1);
  localparam logic [LW-1:0] LowMax = LW'(A12_LOW_MIN);

  logic          sync1_q, sync2_q;
  logic [1:0]    valid_q;
  logic [LW-1:0] low_cnt_q, low_cnt_d;

  // Only samples that actually crossed the synchroniser count as low time, so
  // the reset value of the flops never qualifies an early edge.
  always_comb begin
    low_cnt_d = low_cnt_q;
    if (sync2_q) begin
      low_cnt_d = '0;
    end else if (valid_q[1] && (low_cnt_q != LowMax)) begin
      low_cnt_d = low_cnt_q + LW'(1);
    end
  end

  always_ff @(posedge m2 or negedge not_reset) begin
    if (!not_reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      valid_q   <= 2'b00;
      low_cnt_q <= '0;
    end else if (ENABLE) begin
      sync1_q   <= ppu_a12;
      sync2_q   <= sync1_q;
      valid_q   <= {valid_q[0], 1'b1};
      low_cnt_q <= low_cnt_d;
    end
  end

  // low_cnt_q is cleared one cycle after A12 goes high, so a held-high A12
  // yields a single pulse.
  assign a12_clock = ENABLE && sync2_q && (low_cnt_q == LowMax);

endmodule

// File: rtl/scanline_irq_scheduler.sv
// MMC3-style scanline counter: reloads/decrements on filtered A12 rises and
// raises an active-low IRQ when the counter reaches zero while enabled.
module scanline_irq_scheduler #(
  parameter bit          ENABLE_SCANLINE_IRQ = scanline_irq_scheduler_pkg::ENABLE_SCANLINE_IRQ,
  parameter int unsigned A12_LOW_MIN         = 3,
  parameter bit          NEW_IRQ_MODE        = 1'b1
) (
  input logic                     m2,
  input logic                     not_reset,
  scanline_irq_scheduler_if.slave bus
);

  import scanline_irq_scheduler_pkg::*;

  logic       a12_clock;
  logic       wr;
  reg_sel_e   sel;
  logic       reload_hit;
  logic [7:0] counter_q, counter_d;
  logic [7:0] reload_value_q, reload_value_d;
  logic       reload_flag_q, reload_flag_d;
  logic       irq_enable_q, irq_enable_d;
  logic       irq_pending_q, irq_pending_d;

  a12_edge_filter #(
    .A12_LOW_MIN (A12_LOW_MIN),
    .ENABLE      (ENABLE_SCANLINE_IRQ)
  ) u_filter (
    .m2        (m2),
    .not_reset (not_reset),
    .ppu_a12   (bus.ppu_a12),
    .a12_clock (a12_clock)
  );

  assign wr  = ENABLE_SCANLINE_IRQ && !bus.romsel && !bus.cpu_rw_in && bus.cpu_addr_in[14];
  assign sel = reg_sel_of(bus.cpu_addr_in);

  always_comb begin
    counter_d      = counter_q;
    reload_value_d = reload_value_q;
    reload_flag_d  = reload_flag_q;
    irq_enable_d   = irq_enable_q;
    irq_pending_d  = irq_pending_q;
    reload_hit     = 1'b0;

    // A $C001 write on the same edge swallows the clock event entirely.
    if (a12_clock && !(wr && (sel == RegC001))) begin
      if ((counter_q == 8'd0) || reload_flag_q) begin
        counter_d     = reload_value_q;
        reload_flag_d = 1'b0;
        reload_hit    = 1'b1;
      end else begin
        counter_d = counter_q - 8'd1;
      end
      if (irq_enable_q && (counter_d == 8'd0) && (NEW_IRQ_MODE || !reload_hit)) begin
        irq_pending_d = 1'b1;
      end
    end

    if (wr) begin
      unique case (sel)
        RegC000: reload_value_d = bus.cpu_data_in;
        RegC001: begin
          reload_flag_d = 1'b1;
          counter_d     = 8'd0;
        end
        RegE000: begin
          irq_enable_d  = 1'b0;
          irq_pending_d = 1'b0;
        end
        RegE001: irq_enable_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge m2 or negedge not_reset) begin
    if (!not_reset) begin
      counter_q      <= 8'd0;
      reload_value_q <= 8'd0;
      reload_flag_q  <= 1'b0;
      irq_enable_q   <= 1'b0;
      irq_pending_q  <= 1'b0;
    end else begin
      counter_q      <= counter_d;
      reload_value_q <= reload_value_d;
      reload_flag_q  <= reload_flag_d;
      irq_enable_q   <= irq_enable_d;
      irq_pending_q  <= irq_pending_d;
    end
  end

  assign bus.irq         = ~irq_pending_q;
  assign bus.irq_pending = irq_pending_q;

endmodule

// File: tb/tb_scanline_irq_scheduler.sv
// Bench for scanline_irq_scheduler: directed vector table, corner sequences and
// a random phase, all checked against a sample-history reference model.
module tb_scanline_irq_scheduler;

  localparam int LowMin = 3;

  logic m2 = 1'b0;
  logic not_reset;

  scanline_irq_scheduler_if bus ();
  scanline_irq_scheduler_if bus_old ();

  assign bus_old.romsel      = bus.romsel;
  assign bus_old.cpu_rw_in   = bus.cpu_rw_in;
  assign bus_old.cpu_addr_in = bus.cpu_addr_in;
  assign bus_old.cpu_data_in = bus.cpu_data_in;
  assign bus_old.ppu_a12     = bus.ppu_a12;

  scanline_irq_scheduler #(
    .ENABLE_SCANLINE_IRQ (1'b1),
    .A12_LOW_MIN         (LowMin),
    .NEW_IRQ_MODE        (1'b1)
  ) dut (
    .m2        (m2),
    .not_reset (not_reset),
    .bus       (bus)
  );

  scanline_irq_scheduler #(
    .ENABLE_SCANLINE_IRQ (1'b1),
    .A12_LOW_MIN         (LowMin),
    .NEW_IRQ_MODE        (1'b0)
  ) dut_old (
    .m2        (m2),
    .not_reset (not_reset),
    .bus       (bus_old)
  );

  always #5 m2 = ~m2;

  // Reference model state; m_pend[1] is the new-mode DUT, m_pend[0] the old-mode one.
  bit       hist[$];
  bit [7:0] m_cnt, m_rv;
  bit       m_flag, m_en;
  bit       m_pend[2];

  int n_total = 0;
  int n_bad   = 0;

  typedef enum {OpWr, OpRise} op_e;
  typedef struct {
    op_e      op;
    bit [1:0] sel;
    bit [7:0] data;
    int       lows;
    bit [7:0] cnt;
    bit       irq_n;
    bit       irq_o;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_cnt = 8'd0; m_rv = 8'd0; m_flag = 1'b0; m_en = 1'b0;
    m_pend[0] = 1'b0; m_pend[1] = 1'b0;
  endtask

  // hist[k-1] is the A12 sample taken at the k-th edge after reset release.
  // The edge-j event needs sample j-2 high after LowMin low samples before it.
  function automatic bit model_event();
    int j = hist.size();
    if (j < 3 + LowMin) return 1'b0;
    if (!hist[j-3]) return 1'b0;
    for (int k = 1; k <= LowMin; k++) if (hist[j-3-k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit wr, ev, reloaded;
    bit [1:0] sel;
    bit [7:0] nc;
    hist.push_back(bus.ppu_a12);
    ev  = model_event();
    wr  = !bus.romsel && !bus.cpu_rw_in && bus.cpu_addr_in[14];
    sel = {bus.cpu_addr_in[13], bus.cpu_addr_in[0]};
    nc  = m_cnt;
    reloaded = 1'b0;
    if (ev && !(wr && sel == 2'b01)) begin
      if (m_cnt == 8'd0 || m_flag) begin
        nc = m_rv; m_flag = 1'b0; reloaded = 1'b1;
      end else begin
        nc = m_cnt - 8'd1;
      end
      if (m_en && nc == 8'd0) begin
        m_pend[1] = 1'b1;
        if (!(reloaded && m_rv == 8'd0)) m_pend[0] = 1'b1;
      end
    end
    m_cnt = nc;
    if (wr) begin
      case (sel)
        2'b00: m_rv = bus.cpu_data_in;
        2'b01: begin m_flag = 1'b1; m_cnt = 8'd0; end
        2'b10: begin m_en = 1'b0; m_pend[0] = 1'b0; m_pend[1] = 1'b0; end
        default: m_en = 1'b1;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge m2);
    model_step();
    #1;
    check("irq", 32'(bus.irq), 32'(!m_pend[1]));
    check("irq_pending", 32'(bus.irq_pending), 32'(m_pend[1]));
    check("irq_old_mode", 32'(bus_old.irq), 32'(!m_pend[0]));
    check("counter", 32'(dut.counter_q), 32'(m_cnt));
    @(negedge m2);
  endtask

  task automatic set_idle();
    bus.romsel = 1'b1; bus.cpu_rw_in = 1'b1;
    bus.cpu_addr_in = 15'd0; bus.cpu_data_in = 8'd0;
  endtask

  task automatic reg_write(input bit [1:0] sel, input bit [7:0] data);
    bus.romsel = 1'b0; bus.cpu_rw_in = 1'b0;
    bus.cpu_addr_in = {1'b1, sel[1], 12'h5a5, sel[0]};
    bus.cpu_data_in = data;
    tick();
    set_idle();
  endtask

  task automatic a12_rise(input int lows);
    bus.ppu_a12 = 1'b0;
    repeat (lows) tick();
    bus.ppu_a12 = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    int run, r;
    vecs[0]  = '{OpWr,   2'b00, 8'd3, 0, 8'd3 - 8'd3, 1'b1, 1'b1};
    vecs[1]  = '{OpWr,   2'b01, 8'd0, 0, 8'd0, 1'b1, 1'b1};
    vecs[2]  = '{OpWr,   2'b11, 8'd0, 0, 8'd0, 1'b1, 1'b1};
    vecs[3]  = '{OpRise, 2'b00, 8'd0, 4, 8'd3, 1'b1, 1'b1};
    vecs[4]  = '{OpRise, 2'b00, 8'd0, 4, 8'd2, 1'b1, 1'b1};
    vecs[5]  = '{OpRise, 2'b00, 8'd0, 4, 8'd1, 1'b1, 1'b1};
    vecs[6]  = '{OpRise, 2'b00, 8'd0, 4, 8'd0, 1'b0, 1'b0};
    vecs[7]  = '{OpRise, 2'b00, 8'd0, 4, 8'd3, 1'b0, 1'b0};
    vecs[8]  = '{OpWr,   2'b10, 8'd0, 0, 8'd3, 1'b1, 1'b1};
    vecs[9]  = '{OpWr,   2'b11, 8'd0, 0, 8'd3, 1'b1, 1'b1};
    vecs[10] = '{OpRise, 2'b00, 8'd0, 2, 8'd3, 1'b1, 1'b1};
    vecs[11] = '{OpRise, 2'b00, 8'd0, 3, 8'd2, 1'b1, 1'b1};
    vecs[12] = '{OpWr,   2'b00, 8'd0, 0, 8'd2, 1'b1, 1'b1};
    vecs[13] = '{OpWr,   2'b01, 8'd0, 0, 8'd0, 1'b1, 1'b1};
    vecs[14] = '{OpRise, 2'b00, 8'd0, 4, 8'd0, 1'b0, 1'b1};
    vecs[15] = '{OpWr,   2'b10, 8'd0, 0, 8'd0, 1'b1, 1'b1};

    not_reset = 1'b0;
    set_idle();
    bus.ppu_a12 = 1'b0;
    model_reset();
    #2;
    check("reset_irq", 32'(bus.irq), 32'd1);
    check("reset_irq_pending", 32'(bus.irq_pending), 32'd0);
    check("reset_irq_old", 32'(bus_old.irq), 32'd1);
    @(negedge m2);
    not_reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].op == OpWr) reg_write(vecs[i].sel, vecs[i].data);
      else a12_rise(vecs[i].lows);
      check($sformatf("vec%0d_counter", i), 32'(dut.counter_q), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_irq", i), 32'(bus.irq), 32'(vecs[i].irq_n));
      check($sformatf("vec%0d_irq_old", i), 32'(bus_old.irq), 32'(vecs[i].irq_o));
    end

    // A12 held high: one event only.
    reg_write(2'b00, 8'd9);
    a12_rise(4);
    check("reload_9", 32'(dut.counter_q), 32'd9);
    repeat (20) tick();
    check("held_high_single_event", 32'(dut.counter_q), 32'd9);

    // $C001 on the event edge wins and the event is dropped.
    bus.ppu_a12 = 1'b0;
    repeat (4) tick();
    bus.ppu_a12 = 1'b1;
    repeat (2) tick();
    reg_write(2'b01, 8'd0);
    check("collision_counter", 32'(dut.counter_q), 32'd0);
    check("collision_flag", 32'(dut.reload_flag_q), 32'd1);
    repeat (2) tick();
    a12_rise(4);
    check("collision_next_reload", 32'(dut.counter_q), 32'd9);

    // Reset mid-operation with irq asserted and counter at 5.
    reg_write(2'b11, 8'd0);
    reg_write(2'b00, 8'd0);
    reg_write(2'b01, 8'd0);
    a12_rise(4);
    reg_write(2'b00, 8'd5);
    a12_rise(4);
    check("pre_reset_counter", 32'(dut.counter_q), 32'd5);
    check("pre_reset_irq", 32'(bus.irq), 32'd0);
    not_reset = 1'b0;
    bus.ppu_a12 = 1'b0;
    #1;
    check("async_reset_irq", 32'(bus.irq), 32'd1);
    check("async_reset_pending", 32'(bus.irq_pending), 32'd0);
    check("async_reset_counter", 32'(dut.counter_q), 32'd0);
    check("async_reset_reload_value", 32'(dut.reload_value_q), 32'd0);
    check("async_reset_enable", 32'(dut.irq_enable_q), 32'd0);
    check("async_reset_low_cnt", 32'(dut.u_filter.low_cnt_q), 32'd0);
    model_reset();
    #2;
    not_reset = 1'b1;

    // A rise right after release must not count.
    reg_write(2'b00, 8'd7);
    tick();
    bus.ppu_a12 = 1'b1;
    repeat (4) tick();
    check("early_rise_ignored", 32'(dut.counter_q), 32'd0);
    a12_rise(4);
    check("first_valid_rise", 32'(dut.counter_q), 32'd7);

    run = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        bus.ppu_a12 = ~bus.ppu_a12;
        run = int'($urandom_range(1, 6));
      end
      run--;
      r = int'($urandom_range(0, 7));
      if (r == 0) begin
        bus.romsel = 1'b0; bus.cpu_rw_in = 1'b0;
        bus.cpu_addr_in = {1'b1, 14'($urandom)};
        bus.cpu_data_in = 8'($urandom_range(0, 4));
      end else if (r == 1) begin
        bus.romsel = 1'($urandom_range(0, 1));
        bus.cpu_rw_in = ~bus.romsel;
        bus.cpu_addr_in = 15'($urandom);
        bus.cpu_data_in = 8'($urandom);
      end else begin
        set_idle();
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
